// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle between game logic, the shared 7-segment decoder and the scan controller.
interface seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    load;
   logic [4*NUM_DIGITS-1:0] load_value;
   logic                    load_ack;
   logic                    lead_zero_blank;
   logic [3:0]              dec_data;
   logic [6:0]              dec_seg;
   logic [6:0]              seg_n;
   logic [NUM_DIGITS-1:0]   an_n;
   logic                    frame_done;

   modport master (
      output load, load_value, lead_zero_blank, dec_seg,
      input  load_ack, dec_data, seg_n, an_n, frame_done
   );

   modport slave (
      input  load, load_value, lead_zero_blank, dec_seg,
      output load_ack, dec_data, seg_n, an_n, frame_done
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexes one shared nibble-to-segment decoder across NUM_DIGITS common-anode digits,
// with a double-buffered display value committed only at frame wrap.
//
// state    | meaning
// ST_BLANK | all anodes off for BLANK_CYCLES; decoder fed active[idx]
// ST_SHOW  | anode idx lit for DWELL_CYCLES; seg_n holds the captured pattern
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input logic            clk,
   input logic            rst_n,
   seg_scan_ctrl_if.slave bus
);
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int VW      = 4 * NUM_DIGITS;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic [VW-1:0]    active;
   logic [VW-1:0]    pending;
   logic             pending_valid;
   logic             upper_zero;
   logic             blank_digit;

   assign bus.dec_data = active[{idx, 2'b00} +: 4];

   // Digit idx is a leading zero when it and every more significant nibble are zero.
   always_comb begin
      upper_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= int'(idx) && active[4*i +: 4] != 4'h0) upper_zero = 1'b0;
      end
      blank_digit = bus.lead_zero_blank && (idx != '0) && upper_zero;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_BLANK;
         cnt            <= '0;
         idx            <= '0;
         active         <= '0;
         pending        <= '0;
         pending_valid  <= 1'b0;
         bus.an_n       <= '1;
         bus.seg_n      <= 7'h7F;
         bus.load_ack   <= 1'b0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.load_ack   <= 1'b0;
         bus.frame_done <= 1'b0;
         case (state)
            ST_BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state     <= ST_SHOW;
                  cnt       <= '0;
                  bus.seg_n <= blank_digit ? 7'h7F : bus.dec_seg;
                  bus.an_n  <= ~(NUM_DIGITS'(1) << idx);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_SHOW: begin
               if (cnt == DWELL_LAST) begin
                  state     <= ST_BLANK;
                  cnt       <= '0;
                  bus.seg_n <= 7'h7F;
                  bus.an_n  <= '1;
                  if (idx == IDX_LAST) begin
                     idx            <= '0;
                     bus.frame_done <= 1'b1;
                     if (pending_valid) begin
                        active        <= pending;
                        pending_valid <= 1'b0;
                        bus.load_ack  <= 1'b1;
                     end
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_BLANK;
         endcase
         // A load in the commit cycle re-arms pending for the next frame.
         if (bus.load) begin
            pending       <= bus.load_value;
            pending_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4 digits, dwell 4, blank 2, 24-cycle frame.
module tb_seg_scan_ctrl;
   localparam logic [6:0] S0 = 7'b100_0000;
   localparam logic [6:0] S1 = 7'b111_1001;
   localparam logic [6:0] S2 = 7'b010_0100;
   localparam logic [6:0] S3 = 7'b011_0000;
   localparam logic [6:0] S4 = 7'b001_1001;
   localparam logic [6:0] S5 = 7'b001_0010;
   localparam logic [6:0] S6 = 7'b000_0010;
   localparam logic [6:0] S7 = 7'b111_1000;
   localparam logic [6:0] S8 = 7'b000_0000;
   localparam logic [6:0] S9 = 7'b001_0000;
   localparam logic [6:0] SX = 7'h7F;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   int   ld_cyc [3];
   logic [15:0] ld_val [3];

   seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

   seg_scan_ctrl #(
      .NUM_DIGITS  (4),
      .DWELL_CYCLES(4),
      .BLANK_CYCLES(2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'd0: seg7 = S0;
         4'd1: seg7 = S1;
         4'd2: seg7 = S2;
         4'd3: seg7 = S3;
         4'd4: seg7 = S4;
         4'd5: seg7 = S5;
         4'd6: seg7 = S6;
         4'd7: seg7 = S7;
         4'd8: seg7 = S8;
         4'd9: seg7 = S9;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   always_comb bus.dec_seg = seg7(bus.dec_data);

   // Called at mid-cycle of frame cycle 0; walks 24 cycles and ends at cycle 0 of the next frame.
   // exp_seg is {digit3, digit2, digit1, digit0}.
   task automatic check_frame(input logic [27:0] exp_seg, input logic [15:0] exp_act,
                              input logic fd0, input logic ack0, input string tag);
      int d;
      int p;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_fd;
      logic       e_ack;
      for (int k = 0; k < 24; k++) begin
         d     = k / 6;
         p     = k % 6;
         e_an  = (p < 2) ? 4'hF : ~(4'b0001 << d);
         e_seg = (p < 2) ? 7'h7F : exp_seg[7*d +: 7];
         e_fd  = (k == 0) ? fd0 : 1'b0;
         e_ack = (k == 0) ? ack0 : 1'b0;
         vectors++;
         if (bus.an_n !== e_an) begin
            miscompares++;
            $display("FAIL %s an_n k=%0d got %b want %b", tag, k, bus.an_n, e_an);
         end
         vectors++;
         if (bus.seg_n !== e_seg) begin
            miscompares++;
            $display("FAIL %s seg_n k=%0d got %b want %b", tag, k, bus.seg_n, e_seg);
         end
         vectors++;
         if (bus.dec_data !== exp_act[4*d +: 4]) begin
            miscompares++;
            $display("FAIL %s dec_data k=%0d got %h want %h", tag, k, bus.dec_data, exp_act[4*d +: 4]);
         end
         vectors++;
         if (bus.frame_done !== e_fd) begin
            miscompares++;
            $display("FAIL %s frame_done k=%0d got %b want %b", tag, k, bus.frame_done, e_fd);
         end
         vectors++;
         if (bus.load_ack !== e_ack) begin
            miscompares++;
            $display("FAIL %s load_ack k=%0d got %b want %b", tag, k, bus.load_ack, e_ack);
         end
         bus.load = 1'b0;
         for (int j = 0; j < 3; j++) begin
            if (ld_cyc[j] == k) begin
               bus.load       = 1'b1;
               bus.load_value = ld_val[j];
            end
         end
         @(negedge clk);
      end
      bus.load = 1'b0;
      vectors++;
      if (bus.frame_done !== 1'b1) begin
         miscompares++;
         $display("FAIL %s frame_done at wrap got %b want 1", tag, bus.frame_done);
      end
      ld_cyc = '{-1, -1, -1};
   endtask

   task automatic test_reset();
      rst_n               = 1'b0;
      bus.load            = 1'b0;
      bus.load_value      = 16'h0000;
      bus.lead_zero_blank = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (bus.an_n !== 4'hF) begin
         miscompares++;
         $display("FAIL reset an_n got %b want 1111", bus.an_n);
      end
      vectors++;
      if (bus.seg_n !== 7'h7F) begin
         miscompares++;
         $display("FAIL reset seg_n got %b want 1111111", bus.seg_n);
      end
      vectors++;
      if (bus.load_ack !== 1'b0 || bus.frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset pulses got ack=%b fd=%b want 0 0", bus.load_ack, bus.frame_done);
      end
      vectors++;
      if (bus.dec_data !== 4'h0) begin
         miscompares++;
         $display("FAIL reset dec_data got %h want 0", bus.dec_data);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_idle_scan();
      check_frame({S0, S0, S0, S0}, 16'h0000, 1'b0, 1'b0, "idle0");
      check_frame({S0, S0, S0, S0}, 16'h0000, 1'b1, 1'b0, "idle1");
   endtask

   task automatic test_load_commit();
      ld_cyc = '{8, -1, -1};
      ld_val = '{16'h1234, 16'h0, 16'h0};
      check_frame({S0, S0, S0, S0}, 16'h0000, 1'b1, 1'b0, "load_pre");
      check_frame({S1, S2, S3, S4}, 16'h1234, 1'b1, 1'b1, "load_1234");
   endtask

   task automatic test_lead_zero();
      bus.lead_zero_blank = 1'b1;
      ld_cyc = '{3, -1, -1};
      ld_val = '{16'h0005, 16'h0, 16'h0};
      check_frame({S1, S2, S3, S4}, 16'h1234, 1'b1, 1'b0, "lzb_1234");
      ld_cyc = '{5, -1, -1};
      ld_val = '{16'h0105, 16'h0, 16'h0};
      check_frame({SX, SX, SX, S5}, 16'h0005, 1'b1, 1'b1, "lzb_0005");
      ld_cyc = '{20, -1, -1};
      ld_val = '{16'h0000, 16'h0, 16'h0};
      check_frame({SX, S1, S0, S5}, 16'h0105, 1'b1, 1'b1, "lzb_0105");
      check_frame({SX, SX, SX, S0}, 16'h0000, 1'b1, 1'b1, "lzb_0000");
      bus.lead_zero_blank = 1'b0;
      check_frame({S0, S0, S0, S0}, 16'h0000, 1'b1, 1'b0, "lzb_off");
   endtask

   task automatic test_back_to_back();
      ld_cyc = '{4, 10, 23};
      ld_val = '{16'h1111, 16'h2222, 16'h3333};
      check_frame({S0, S0, S0, S0}, 16'h0000, 1'b1, 1'b0, "merge_pre");
      check_frame({S2, S2, S2, S2}, 16'h2222, 1'b1, 1'b1, "merge_2222");
      check_frame({S3, S3, S3, S3}, 16'h3333, 1'b1, 1'b1, "merge_3333");
      ld_cyc = '{12, -1, -1};
      ld_val = '{16'h9876, 16'h0, 16'h0};
      check_frame({S3, S3, S3, S3}, 16'h3333, 1'b1, 1'b0, "merge_hold");
   endtask

   task automatic test_reset_mid();
      vectors++;
      if (bus.load_ack !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid ack_9876 got %b want 1", bus.load_ack);
      end
      for (int k = 0; k < 14; k++) begin
         bus.load       = (k == 10);
         bus.load_value = 16'h5555;
         @(negedge clk);
      end
      bus.load = 1'b0;
      vectors++;
      if (bus.an_n !== 4'b1011 || bus.seg_n !== S8) begin
         miscompares++;
         $display("FAIL rstmid digit2 got an=%b seg=%b want 1011 %b", bus.an_n, bus.seg_n, S8);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.an_n !== 4'hF || bus.seg_n !== 7'h7F) begin
         miscompares++;
         $display("FAIL rstmid outputs got an=%b seg=%b want 1111 1111111", bus.an_n, bus.seg_n);
      end
      vectors++;
      if (bus.load_ack !== 1'b0 || bus.frame_done !== 1'b0 || bus.dec_data !== 4'h0) begin
         miscompares++;
         $display("FAIL rstmid pulses got ack=%b fd=%b dec=%h want 0 0 0",
                  bus.load_ack, bus.frame_done, bus.dec_data);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_frame({S0, S0, S0, S0}, 16'h0000, 1'b0, 1'b0, "rstmid_f0");
      check_frame({S0, S0, S0, S0}, 16'h0000, 1'b1, 1'b0, "rstmid_f1");
   endtask

   task automatic test_hex_digits();
      ld_cyc = '{7, -1, -1};
      ld_val = '{16'hF0A0, 16'h0, 16'h0};
      check_frame({S0, S0, S0, S0}, 16'h0000, 1'b1, 1'b0, "hex_pre");
      check_frame({SX, S0, SX, S0}, 16'hF0A0, 1'b1, 1'b1, "hex_f0a0");
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      ld_cyc      = '{-1, -1, -1};
      ld_val      = '{16'h0, 16'h0, 16'h0};
      test_reset();
      test_idle_scan();
      test_load_commit();
      test_lead_zero();
      test_back_to_back();
      test_reset_mid();
      test_hex_digits();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of sequence");
      $fatal(1, "timeout");
   end
endmodule
